instr_prefetch_buffer: RTL and testbench
========================================

// Module: instr_prefetch_buffer
// PURPOSE
//  Instruction fetch front end: issues sequential word fetches to instruction memory over a req/gnt/rvalid bus,
//  buffers returned words with their PCs in a small in-order queue, and presents them to the IF/ID register
//  through a valid/ready handshake. Sits directly upstream of the pipeline core. A redirect from EX
//  (branch/jump target) flushes the queue and squashes in-flight responses.
// PARAMETERS
//  DEPTH      4   queue entries; also the maximum number of outstanding memory requests (power of 2, >=2)
//  XLEN       32  address/instruction width
// PORTS
//  clk            in   1     clock, rising edge
//  rst_n          in   1     asynchronous active-low reset
//  boot_addr      in   XLEN  first fetch PC after reset, sampled in the cycle after rst_n deasserts
//  redirect_valid in   1     EX stage requests PC load this cycle
//  redirect_pc    in   XLEN  redirect target; bits[1:0] ignored (treated as 0)
//  imem_req       out  1     fetch request valid
//  imem_addr      out  XLEN  word-aligned fetch address
//  imem_gnt       in   1     request accepted when imem_req && imem_gnt
//  imem_rvalid    in   1     response valid; responses return in request order, >=1 cycle after gnt
//  imem_rdata     in   XLEN  response instruction word
//  fetch_valid    out  1     fetch_instr/fetch_pc valid for the core
//  fetch_ready    in   1     core accepts entry when fetch_valid && fetch_ready
//  fetch_instr    out  XLEN  instruction word
//  fetch_pc       out  XLEN  PC of fetch_instr
// BEHAVIOUR
//  - Reset: imem_req=0, imem_addr=0, fetch_valid=0, fetch_instr=NOP (0x00000013), fetch_pc=0; queue empty,
//    outstanding=0, discard=0; FSM=BOOT.
//  - FSM: BOOT -> RUN after one cycle (loads fetch address from boot_addr). RUN -> RUN. No other states;
//    stale-response squashing is handled by the discard counter, not a state.
//  - imem_req=1 in RUN iff (queue count + outstanding) < DEPTH and no redirect this cycle.
//  - On req&&gnt: outstanding+1, fetch address += 4 (wraps modulo 2^XLEN; 0xFFFFFFFC -> 0x0). While req&&!gnt,
//    imem_addr holds stable; req may only drop on redirect.
//  - On rvalid: if discard>0 -> discard-1, word dropped; else push {rdata, pc} into queue. outstanding-1 either way.
//    Pushed PC = PC of the oldest live request (tracked by a response-PC register advanced by 4 per push).
//  - Queue head drives fetch_*; pop on fetch_valid&&fetch_ready. Simultaneous push+pop at full is legal.
//    Push when full cannot occur (credit rule above); assertion required.
//  - Redirect (highest priority): queue flushed, fetch_valid=0 next cycle, fetch address and response-PC := redirect_pc
//    & ~3, discard := outstanding minus (1 if rvalid this cycle), imem_req forced 0 this cycle, and any pop or push
//    this cycle is discarded. Fetching at new PC starts next cycle.
//  - Back-to-back redirects: latest wins; discard recomputed each time from current outstanding.
//  - Reset mid-transaction: all state cleared immediately; environment must also drop pending responses.
//  - Latency (bypass off): gnt at cycle N, rvalid at N+k -> fetch_valid at N+k+1.
// CONFIGURATION
//  FETCH_BYPASS_EN defined: when queue empty, no discard pending and rvalid, response is presented on fetch_*
//    combinationally in the same cycle; if fetch_ready it is consumed without entering the queue, else it is pushed.
//  Undefined: every response is registered through the queue (1-cycle extra latency, no rdata->fetch_* path).
// STRUCTURE
//  - rv32_pkg: XLEN, NOP_INSTR constant, fetch_entry_t typedef {instr, pc}, fetch_state_e enum {BOOT, RUN}.
//  - Sub-module sync_fifo (parameter DEPTH, WIDTH; push/pop/flush, count, full/empty) holds fetch_entry_t.
//  - Top holds FSM, fetch address, response-PC, outstanding and discard counters ($clog2(DEPTH)+1 bits).
// TESTING
//  1. Reset, boot_addr=0x1000, gnt=1, rvalid 1 cycle later, ready=1 -> fetch_pc 0x1000,0x1004,0x1008 in order.
//  2. fetch_ready=0, memory always granting -> exactly 4 requests issued, queue full, imem_req=0 until a pop.
//  3. 3 requests outstanding, redirect to 0x2002 -> 3 responses dropped, next fetch_pc=0x2000, no stale word out.
//  4. redirect in the same cycle as rvalid and fetch pop -> discard=outstanding-1, queue empty, no output beat.
//  5. imem_gnt held 0 for 5 cycles -> imem_req and imem_addr stable throughout; fetch_valid stays 0.
//  6. Fetch from 0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; with FETCH_BYPASS_EN, empty queue
//     and ready=1 -> fetch_valid in the rvalid cycle; without, one cycle later.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared types and constants for the RV32 instruction fetch front end.
//   XLEN          address / instruction width
//   NOP_INSTR     canonical NOP (addi x0, x0, 0) shown on fetch_instr when nothing is valid
//   fetch_entry_t one buffered fetch: instruction word plus its PC
//   fetch_state_e fetch FSM states
package rv32_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    BOOT,
    RUN
  } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous in-order FIFO with flush.
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   push, wdata  write request and data
//   pop          read request; rdata always shows the head entry
//   flush        empties the FIFO, overriding push/pop in the same cycle
//   count        number of valid entries (0..DEPTH)
//   full, empty  occupancy flags
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push at full is only accepted when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  push_when_full_a : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: sequential word fetches over a req/gnt/rvalid bus, returned words
// queued in order with their PCs and handed to IF/ID through valid/ready. A redirect from EX
// flushes the queue and squashes the responses still in flight.
// Optional feature macro: FETCH_BYPASS_EN -- when the queue is empty and nothing is being
// discarded, a response is presented on fetch_* in its rvalid cycle.
// Ports:
//   clk, rst_n                       clock / asynchronous active-low reset
//   boot_addr                        first PC, sampled in the BOOT cycle
//   redirect_valid, redirect_pc      PC load from EX (bits [1:0] ignored)
//   imem_req/addr/gnt                request channel
//   imem_rvalid/rdata                in-order response channel
//   fetch_valid/ready/instr/pc       handshake towards the core
module instr_prefetch_buffer
  import rv32_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] boot_addr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_instr,
  output logic [XLEN-1:0] fetch_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CreditMax = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] AddrMask = ~XLEN'(3);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   discard_q, discard_d;

  fetch_entry_t    fifo_wdata, fifo_rdata;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty, fifo_push, fifo_pop;

  logic [CW:0]     credit_used;
  logic            imem_accept, rsp_drop, rsp_live, bypass_avail, bypass_take;

  // Every queue slot is pre-reserved by an outstanding request, so the queue never overflows.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outst_q};
  assign imem_req    = (state_q == RUN) && !redirect_valid && (credit_used < CreditMax)
                       && !fifo_full;
  assign imem_addr   = fetch_addr_q;
  assign imem_accept = imem_req && imem_gnt;

  assign rsp_drop = imem_rvalid && (discard_q != '0);
  assign rsp_live = imem_rvalid && (discard_q == '0) && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign bypass_avail = fifo_empty && rsp_live;
`else
  assign bypass_avail = 1'b0;
`endif
  assign bypass_take = bypass_avail && fetch_ready;

  assign fifo_push        = rsp_live && !bypass_take;
  assign fifo_pop         = !fifo_empty && fetch_ready && !redirect_valid;
  assign fifo_wdata.instr = imem_rdata;
  assign fifo_wdata.pc    = resp_pc_q;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    fetch_valid = !fifo_empty;
    fetch_instr = fifo_empty ? NOP_INSTR : fifo_rdata.instr;
    fetch_pc    = fifo_empty ? '0 : fifo_rdata.pc;
    if (bypass_avail) begin
      fetch_valid = 1'b1;
      fetch_instr = imem_rdata;
      fetch_pc    = resp_pc_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    resp_pc_d    = resp_pc_q;
    outst_d      = outst_q;
    discard_d    = discard_q;

    if (imem_accept && !imem_rvalid)      outst_d = outst_q + CW'(1);
    else if (!imem_accept && imem_rvalid) outst_d = outst_q - CW'(1);

    if (imem_accept) fetch_addr_d = fetch_addr_q + XLEN'(4);
    if (rsp_drop)    discard_d    = discard_q - CW'(1);
    // resp_pc tracks the PC of the oldest live request still owed a word.
    if (fifo_push || bypass_take) resp_pc_d = resp_pc_q + XLEN'(4);

    if (state_q == BOOT) begin
      state_d      = RUN;
      fetch_addr_d = boot_addr & AddrMask;
      resp_pc_d    = boot_addr & AddrMask;
    end

    // No request goes out during a redirect, so outst_d is exactly the number of stale words.
    if (redirect_valid) begin
      state_d      = RUN;
      fetch_addr_d = redirect_pc & AddrMask;
      resp_pc_d    = redirect_pc & AddrMask;
      discard_d    = outst_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      fetch_addr_q <= '0;
      resp_pc_q    <= '0;
      outst_q      <= '0;
      discard_q    <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      resp_pc_q    <= resp_pc_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
module tb_instr_prefetch_buffer;
  import rv32_pkg::*;

  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam int EXP_LAT = 0;
`else
  localparam int EXP_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] boot_addr = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        fetch_valid;
  logic        fetch_ready = 1'b1;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;

  instr_prefetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .boot_addr      (boot_addr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_instr    (fetch_instr),
    .fetch_pc       (fetch_pc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memfun(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0BAD_F00D;
  endfunction

  // Memory side: granted requests waiting to be answered.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mem_q[$];
  int    cyc = 0;
  int    lat = 1;
  bit    gnt_en = 1'b1;

  // Reference model: every granted request carries the redirect epoch it was issued in; a word
  // is delivered only if its epoch is still current, in order, and nothing is buffered beyond
  // DEPTH words plus requests in flight.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
  } infl_t;
  infl_t        infl_q[$];
  fetch_entry_t exp_q[$];
  int           epoch = 0;
  logic [31:0]  exp_addr = '0;
  bit           in_boot = 1'b1;
  bit           prev_stall = 1'b0;
  logic [31:0]  prev_addr = '0;

  logic [31:0]  beat_pcs[$];
  int           beat_cycs[$];
  logic [31:0]  grant_addrs[$];
  int           live_rv_cycs[$];

  always @(negedge clk) begin : mon
    bit           rv_ok, live, have, exp_req;
    fetch_entry_t head;
    if (!rst_n) begin
      chk1("rst_imem_req", imem_req, 1'b0);
      chk("rst_imem_addr", imem_addr, 32'h0);
      chk1("rst_fetch_valid", fetch_valid, 1'b0);
      chk("rst_fetch_instr", fetch_instr, NOP_INSTR);
      chk("rst_fetch_pc", fetch_pc, 32'h0);
      infl_q.delete();
      exp_q.delete();
      in_boot    = 1'b1;
      prev_stall = 1'b0;
      epoch++;
    end else begin
      rv_ok = imem_rvalid && (infl_q.size() > 0);
      live  = rv_ok && (infl_q[0].epoch == epoch) && !redirect_valid;
      if (imem_rvalid && infl_q.size() == 0) chk1("rvalid_without_request", 1'b1, 1'b0);

      if (in_boot) begin
        chk1("boot_imem_req", imem_req, 1'b0);
        chk1("boot_fetch_valid", fetch_valid, 1'b0);
      end else begin
        exp_req = !redirect_valid && ((exp_q.size() + infl_q.size()) < DEPTH);
        chk1("imem_req", imem_req, exp_req);
        if (imem_req) chk("imem_addr", imem_addr, exp_addr);
        if (prev_stall && !redirect_valid) begin
          chk1("req_hold_while_stalled", imem_req, 1'b1);
          chk("addr_hold_while_stalled", imem_addr, prev_addr);
        end
        have = 1'b0;
        head = '{instr: NOP_INSTR, pc: 32'h0};
        if (exp_q.size() > 0) begin
          have = 1'b1;
          head = exp_q[0];
        end
`ifdef FETCH_BYPASS_EN
        else if (live) begin
          have = 1'b1;
          head = '{instr: memfun(infl_q[0].addr), pc: infl_q[0].addr};
        end
`endif
        chk1("fetch_valid", fetch_valid, have);
        if (have) begin
          chk("fetch_pc", fetch_pc, head.pc);
          chk("fetch_instr", fetch_instr, head.instr);
        end
      end

      // Transfers that take place at the coming rising edge.
      prev_stall = imem_req && !imem_gnt;
      prev_addr  = imem_addr;
      if (rv_ok) begin
        if (live) begin
          exp_q.push_back('{instr: memfun(infl_q[0].addr), pc: infl_q[0].addr});
          live_rv_cycs.push_back(cyc);
        end
        infl_q.delete(0);
      end
      if (imem_req && imem_gnt) begin
        infl_q.push_back('{addr: imem_addr, epoch: epoch});
        mem_q.push_back('{addr: imem_addr, due: cyc + lat});
        grant_addrs.push_back(imem_addr);
        exp_addr = exp_addr + 32'd4;
      end
      if (fetch_valid && fetch_ready && !redirect_valid && !in_boot) begin
        beat_pcs.push_back(fetch_pc);
        beat_cycs.push_back(cyc);
        if (exp_q.size() > 0) exp_q.delete(0);
        else chk1("unexpected_beat", 1'b1, 1'b0);
      end
      if (redirect_valid) begin
        epoch++;
        exp_q.delete();
        exp_addr   = redirect_pc & ~32'h3;
        prev_stall = 1'b0;
      end
      if (in_boot) begin
        if (!redirect_valid) exp_addr = boot_addr & ~32'h3;
        in_boot = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    redirect_valid = 1'b0;
    imem_gnt = gnt_en;
    if (rst_n && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memfun(mem_q[0].addr);
      mem_q.delete(0);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  task automatic do_reset(input logic [31:0] ba);
    rst_n = 1'b0;
    imem_rvalid = 1'b0;
    redirect_valid = 1'b0;
    mem_q.delete();
    boot_addr = ba;
    tick();
    tick();
    rst_n = 1'b1;
    beat_pcs.delete();
    beat_cycs.delete();
    grant_addrs.delete();
    live_rv_cycs.delete();
  endtask

  initial begin : timeout
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int nb;
    int stale;
    bit found;

    // 1: boot at 0x1000, sequential delivery.
    lat = 1; gnt_en = 1'b1; fetch_ready = 1'b1;
    do_reset(32'h1000);
    repeat (12) tick();
    chk1("t1_three_beats", beat_pcs.size() >= 3, 1'b1);
    chk("t1_pc0", beat_pcs[0], 32'h1000);
    chk("t1_pc1", beat_pcs[1], 32'h1004);
    chk("t1_pc2", beat_pcs[2], 32'h1008);

    // 2: core stalled -> exactly DEPTH requests, then req held low until a pop.
    fetch_ready = 1'b0;
    do_reset(32'h1000);
    repeat (12) tick();
    #2;
    chk("t2_grants", 32'(grant_addrs.size()), 32'd4);
    chk1("t2_req_low_full", imem_req, 1'b0);
    chk1("t2_valid", fetch_valid, 1'b1);
    chk("t2_head_pc", fetch_pc, 32'h1000);
    fetch_ready = 1'b1;
    tick();
    fetch_ready = 1'b0;
    tick();
    chk("t2_grant_after_pop", 32'(grant_addrs.size()), 32'd5);
    chk("t2_fifth_addr", grant_addrs[4], 32'h1010);

    // 3: three requests in flight, redirect to an unaligned target.
    fetch_ready = 1'b1; lat = 8;
    do_reset(32'h1000);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (grant_addrs.size() == 3) begin
        found = 1'b1;
        break;
      end
    end
    chk1("t3_three_outstanding", found, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h2002;
    #1;
    chk1("t3_req_forced_low", imem_req, 1'b0);
    repeat (40) tick();
    chk("t3_first_pc", beat_pcs[0], 32'h2000);
    chk("t3_second_pc", beat_pcs[1], 32'h2004);
    stale = 0;
    foreach (beat_pcs[i]) if (beat_pcs[i] < 32'h2000) stale++;
    chk("t3_no_stale", 32'(stale), 32'd0);

    // 4: redirect in a cycle with a response and a pop (also resets mid-transaction first).
    lat = 2;
    do_reset(32'h1000);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      #1;
      if (cyc > 6 && imem_rvalid && fetch_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk1("t4_setup_found", found, 1'b1);
    nb = beat_pcs.size();
    redirect_valid = 1'b1;
    redirect_pc = 32'h3000;
    tick();
    chk("t4_no_beat_on_redirect", 32'(beat_pcs.size()), 32'(nb));
    #1;
    chk1("t4_valid_low_after", fetch_valid, 1'b0);
    repeat (20) tick();
    chk("t4_first_pc", beat_pcs[nb], 32'h3000);
    chk("t4_second_pc", beat_pcs[nb + 1], 32'h3004);

    // 5: grant withheld for five cycles.
    lat = 1; gnt_en = 1'b0;
    do_reset(32'h4000);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk1("t5_req_stable", imem_req, 1'b1);
      chk("t5_addr_stable", imem_addr, 32'h4000);
      chk1("t5_no_valid", fetch_valid, 1'b0);
      tick();
    end
    gnt_en = 1'b1;
    repeat (6) tick();
    chk("t5_first_pc", beat_pcs[0], 32'h4000);

    // 6: address wrap and delivery latency.
    do_reset(32'hFFFF_FFF8);
    repeat (10) tick();
    chk("t6_addr0", grant_addrs[0], 32'hFFFF_FFF8);
    chk("t6_addr1", grant_addrs[1], 32'hFFFF_FFFC);
    chk("t6_addr2", grant_addrs[2], 32'h0000_0000);
    chk("t6_pc2", beat_pcs[2], 32'h0000_0000);
    chk("t6_latency", 32'(beat_cycs[0] - live_rv_cycs[0]), 32'(EXP_LAT));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
